// File: rtl/muldiv_unit_if.sv
// Request/response bundle for muldiv_unit: operation request in, result and status out.
interface muldiv_unit_if;
  logic        Start;
  logic        Op;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] Result;
  logic [15:0] Hi;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  modport master (
    output Start, Op, A, B,
    input  Result, Hi, Busy, Done, DivZero
  );

  modport slave (
    input  Start, Op, A, B,
    output Result, Hi, Busy, Done, DivZero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 16x16 multiply (shift-add) / divide (restoring), fixed 18-cycle latency.
// Define MULDIV_SIGNED_EN to treat A and B as two's complement.
module muldiv_unit (
  input  logic          Clk,
  input  logic          Reset,
  muldiv_unit_if.slave  bus
);

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        op_q;
  logic        neg_a;
  logic        neg_b;
  logic [15:0] a_raw;
  logic [15:0] opnd;      // |A| as multiplicand, or |B| as divisor
  logic [15:0] hi_w;      // product high half / partial remainder
  logic [15:0] lo_w;      // multiplier bits / dividend bits becoming quotient
  logic [15:0] result_q;
  logic [15:0] hi_q;
  logic        busy_q;
  logic        done_q;
  logic        dz_q;

  logic        in_neg_a;
  logic        in_neg_b;
  logic [15:0] in_mag_a;
  logic [15:0] in_mag_b;

  assign in_neg_a = SIGNED && bus.A[15];
  assign in_neg_b = SIGNED && bus.B[15];
  assign in_mag_a = in_neg_a ? (~bus.A + 16'd1) : bus.A;
  assign in_mag_b = in_neg_b ? (~bus.B + 16'd1) : bus.B;

  // One iteration of either algorithm on the shared working registers.
  logic [16:0] sum;
  logic [16:0] rem_sh;
  logic [16:0] trial;
  logic [15:0] hi_nx;
  logic [15:0] lo_nx;

  always_comb begin
    sum    = '0;
    rem_sh = '0;
    trial  = '0;
    hi_nx  = hi_w;
    lo_nx  = lo_w;
    if (!op_q) begin
      sum = {1'b0, hi_w} + (lo_w[0] ? {1'b0, opnd} : 17'd0);
      {hi_nx, lo_nx} = {sum, lo_w[15:1]};
    end else begin
      rem_sh = {hi_w, lo_w[15]};
      trial  = rem_sh - {1'b0, opnd};
      if (!trial[16]) begin
        hi_nx = trial[15:0];
        lo_nx = {lo_w[14:0], 1'b1};
      end else begin
        hi_nx = rem_sh[15:0];
        lo_nx = {lo_w[14:0], 1'b0};
      end
    end
  end

  logic [31:0] prod;
  logic [31:0] prod_fix;
  logic [15:0] quot_fix;
  logic [15:0] rem_fix;

  always_comb begin
    prod     = {hi_w, lo_w};
    prod_fix = (neg_a ^ neg_b) ? (~prod + 32'd1) : prod;
    quot_fix = (neg_a ^ neg_b) ? (~lo_w + 16'd1) : lo_w;
    rem_fix  = neg_a ? (~hi_w + 16'd1) : hi_w;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      a_raw    <= '0;
      opnd     <= '0;
      hi_w     <= '0;
      lo_w     <= '0;
      result_q <= '0;
      hi_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            op_q   <= bus.Op;
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            a_raw  <= bus.A;
            opnd   <= bus.Op ? in_mag_b : in_mag_a;
            hi_w   <= '0;
            lo_w   <= bus.Op ? in_mag_a : in_mag_b;
            cnt    <= '0;
            dz_q   <= 1'b0;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          hi_w <= hi_nx;
          lo_w <= lo_nx;
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd15) state <= FIX;
        end
        FIX: begin
          if (!op_q) begin
            {hi_q, result_q} <= prod_fix;
            dz_q             <= 1'b0;
          end else if (opnd == '0) begin
            result_q <= '1;
            hi_q     <= a_raw;
            dz_q     <= 1'b1;
          end else begin
            result_q <= quot_fix;
            hi_q     <= rem_fix;
            dz_q     <= 1'b0;
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Result  = result_q;
  assign bus.Hi      = hi_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.DivZero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit latency, results, divide-by-zero and reset.
module tb_muldiv_unit;
  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  logic [47:0] sb_q[$];
  logic [15:0] last_res;
  logic [15:0] last_hi;
  logic        last_dz;

  muldiv_unit_if bus();

  muldiv_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // Reference built from native arithmetic operators: {DivZero, Hi, Result}.
  function automatic logic [47:0] model(input logic op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [15:0] q;
    logic [15:0] r;
`ifdef MULDIV_SIGNED_EN
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (!op) begin
      p = 32'(sa * sb);
      return {16'd0, p[31:16], p[15:0]};
    end
    if (b == 16'd0) return {16'd1, a, 16'hFFFF};
    q = 16'(sa / sb);
    r = 16'(sa % sb);
    return {16'd0, r, q};
`else
    int unsigned ua;
    int unsigned ub;
    ua = a;
    ub = b;
    if (!op) begin
      p = ua * ub;
      return {16'd0, p[31:16], p[15:0]};
    end
    if (b == 16'd0) return {16'd1, a, 16'hFFFF};
    q = 16'(ua / ub);
    r = 16'(ua % ub);
    return {16'd0, r, q};
`endif
  endfunction

  task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b, input bit poke);
    int cyc;
    int busy_cnt;
    int extra_done;
    bit got;
    logic [47:0] exp;
    sb_q.push_back(model(op, a, b));
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    bus.Op    = ~op;
    bus.A     = 16'($urandom);
    bus.B     = 16'($urandom);
    cyc = 0;
    busy_cnt = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge Clk);
      cyc++;
      if (bus.Busy === 1'b1) busy_cnt++;
      if (bus.Done === 1'b1) got = 1'b1;
      if (poke) bus.Start = (cyc == 5 || cyc == 17);
    end
    bus.Start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("done_cycle", cyc, 18);
    chk("busy_cycles", busy_cnt, 17);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 48'hx;
    chk("result", 32'(bus.Result), 32'(exp[15:0]));
    chk("hi", 32'(bus.Hi), 32'(exp[31:16]));
    chk("divzero", 32'(bus.DivZero), 32'(exp[32]));
    last_res = bus.Result;
    last_hi  = bus.Hi;
    last_dz  = bus.DivZero;
    @(negedge Clk);
    chk("done_one_cycle", 32'(bus.Done), 32'd0);
    if (poke) begin
      extra_done = 0;
      repeat (22) begin
        @(negedge Clk);
        if (bus.Done === 1'b1) extra_done++;
      end
      chk("poke_no_extra_done", extra_done, 0);
      chk("poke_result_held", 32'(bus.Result), 32'(exp[15:0]));
    end
  endtask

  initial begin
    int dcount;
    logic [15:0] ra;
    logic [15:0] rb;
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Op    = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_result", 32'(bus.Result), 0);
    chk("rst_hi", 32'(bus.Hi), 0);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_divzero", 32'(bus.DivZero), 0);
    Reset = 1'b0;

    run_op(1'b0, 16'h0007, 16'h0006, 1'b0);
    chk("mul7x6_lit_res", 32'(last_res), 32'h002A);
    chk("mul7x6_lit_hi", 32'(last_hi), 32'h0000);

    run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
`ifdef MULDIV_SIGNED_EN
    chk("mulFF_lit_hi", 32'(last_hi), 32'h0000);
`else
    chk("mulFF_lit_hi", 32'(last_hi), 32'hFFFE);
`endif
    chk("mulFF_lit_res", 32'(last_res), 32'h0001);

    run_op(1'b1, 16'd100, 16'd7, 1'b0);
    chk("div100_lit_res", 32'(last_res), 32'h000E);
    chk("div100_lit_hi", 32'(last_hi), 32'h0002);

    run_op(1'b1, 16'h1234, 16'h0000, 1'b0);
    chk("div0_lit_res", 32'(last_res), 32'hFFFF);
    chk("div0_lit_hi", 32'(last_hi), 32'h1234);
    chk("div0_lit_flag", 32'(last_dz), 1);

    run_op(1'b0, 16'h0003, 16'h0005, 1'b0);
    chk("mul_clears_dz", 32'(last_dz), 0);

`ifdef MULDIV_SIGNED_EN
    run_op(1'b1, 16'hFFF9, 16'h0002, 1'b0);
    chk("sdiv_lit_res", 32'(last_res), 32'hFFFD);
    chk("sdiv_lit_hi", 32'(last_hi), 32'hFFFF);
    run_op(1'b1, 16'h8000, 16'hFFFF, 1'b0);
    chk("sdiv_min_res", 32'(last_res), 32'h8000);
    chk("sdiv_min_hi", 32'(last_hi), 32'h0000);
    chk("sdiv_min_flag", 32'(last_dz), 0);
`else
    run_op(1'b1, 16'h8000, 16'hFFFF, 1'b0);
    run_op(1'b1, 16'hFFF9, 16'h0002, 1'b0);
`endif

    run_op(1'b0, 16'h8000, 16'h8000, 1'b0);
    run_op(1'b1, 16'h0000, 16'h0005, 1'b0);
    run_op(1'b1, 16'h0005, 16'h8000, 1'b0);
    run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    run_op(1'b1, 16'h0000, 16'h0000, 1'b0);

    // Start re-asserted during CALC/FIX must not disturb or spawn an operation.
    run_op(1'b1, 16'd5000, 16'd37, 1'b1);

    // Result must hold in IDLE while inputs wander.
    repeat (4) begin
      @(negedge Clk);
      bus.A = 16'($urandom);
      bus.B = 16'($urandom);
    end
    chk("idle_hold_res", 32'(bus.Result), 32'(last_res));
    chk("idle_hold_hi", 32'(bus.Hi), 32'(last_hi));

    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 3) rb = 16'd0;
      run_op(1'(i % 2), ra, rb, 1'b0);
    end

    // Reset in the middle of CALC aborts the operation with no Done.
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op    = 1'b0;
    bus.A     = 16'h1234;
    bus.B     = 16'h5678;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    repeat (5) @(negedge Clk);
    chk("pre_rst_busy", 32'(bus.Busy), 1);
    Reset = 1'b1;
    @(negedge Clk);
    chk("abort_result", 32'(bus.Result), 0);
    chk("abort_hi", 32'(bus.Hi), 0);
    chk("abort_busy", 32'(bus.Busy), 0);
    chk("abort_done", 32'(bus.Done), 0);
    chk("abort_divzero", 32'(bus.DivZero), 0);
    Reset = 1'b0;
    dcount = 0;
    repeat (25) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) dcount++;
    end
    chk("abort_no_done", dcount, 0);

    // Reset wins over Start in the same cycle.
    bus.Start = 1'b1;
    Reset     = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    Reset     = 1'b0;
    chk("rst_over_start_busy", 32'(bus.Busy), 0);
    dcount = 0;
    repeat (22) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) dcount++;
    end
    chk("rst_over_start_no_done", dcount, 0);

    run_op(1'b1, 16'd1000, 16'd3, 1'b0);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
